// File: rtl/dfi_phy_pkg.sv
// Shared types and constants for the DFI loopback PHY: init FSM states,
// error bit positions and init counter width.
package dfi_phy_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRAIN = 2'd1,
    DONE  = 2'd2
  } init_state_e;

  localparam int ERR_UNDERFLOW = 0;
  localparam int ERR_OVERFLOW  = 1;

  // Wide enough for C_INIT_CYCLES up to 255
  localparam int INIT_CNT_W = 8;

endpackage

// File: rtl/dfi_loopback_phy_if.sv
// DFI bus between memory controller (master) and PHY (slave); per-phase
// buses are flat with phase 0 in the LSBs.
interface dfi_loopback_phy_if #(
  parameter int W = 64,
  parameter int E = 4
);

  logic [E-1:0] dfi_wrdata_en;
  logic [W-1:0] dfi_wrdata;
  logic [E-1:0] dfi_rddata_en;
  logic [W-1:0] dfi_rddata;
  logic [E-1:0] dfi_rddata_valid;
  logic         dfi_init_start;
  logic         dfi_init_complete;
  logic         dfi_ctrlupd_req;
  logic         dfi_ctrlupd_ack;
  logic         dfi_lp_ctrl_req;
  logic         dfi_lp_data_req;
  logic         dfi_lp_ack;
  logic         dfi_phyupd_req;
  logic [1:0]   dfi_phyupd_type;
  logic         dfi_alert_n;
  logic [1:0]   dfi_error;

  modport master (
    output dfi_wrdata_en, dfi_wrdata, dfi_rddata_en, dfi_init_start,
           dfi_ctrlupd_req, dfi_lp_ctrl_req, dfi_lp_data_req,
    input  dfi_rddata, dfi_rddata_valid, dfi_init_complete, dfi_ctrlupd_ack,
           dfi_lp_ack, dfi_phyupd_req, dfi_phyupd_type, dfi_alert_n, dfi_error
  );

  modport slave (
    input  dfi_wrdata_en, dfi_wrdata, dfi_rddata_en, dfi_init_start,
           dfi_ctrlupd_req, dfi_lp_ctrl_req, dfi_lp_data_req,
    output dfi_rddata, dfi_rddata_valid, dfi_init_complete, dfi_ctrlupd_ack,
           dfi_lp_ack, dfi_phyupd_req, dfi_phyupd_type, dfi_alert_n, dfi_error
  );

endinterface

// File: rtl/dfi_phy_fifo.sv
// Synchronous FIFO holding captured write beats. Pop is evaluated against the
// count before any same-cycle push, so there is no write-to-read bypass.
module dfi_phy_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when a pop frees a slot the same cycle
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/dfi_loopback_phy.sv
// PHY-side DFI responder: completes init/ctrlupd/lp handshakes and loops
// captured write beats back as read data after a fixed read latency.
module dfi_loopback_phy
  import dfi_phy_pkg::*;
#(
  parameter int C_DFI_FREQ_RATIO   = 4,
  parameter int C_DFI_DATA_WIDTH   = 16,
  parameter int C_DFI_DATAEN_WIDTH = 1,
  parameter int C_TPHY_WRDATA      = 1,
  parameter int C_TPHY_RDLAT       = 4,
  parameter int C_INIT_CYCLES      = 16,
  parameter int C_FIFO_DEPTH       = 16
) (
  input  logic              aclk,
  input  logic              aresetn,
  dfi_loopback_phy_if.slave dfi
);

  localparam int W = C_DFI_DATA_WIDTH * C_DFI_FREQ_RATIO;
  localparam int E = C_DFI_DATAEN_WIDTH * C_DFI_FREQ_RATIO;

  init_state_e           state;
  logic [INIT_CNT_W-1:0] init_cnt;
  logic                  active;

  assign active = (state == DONE);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= IDLE;
      init_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dfi.dfi_init_start) begin
            state    <= TRAIN;
            init_cnt <= INIT_CNT_W'(C_INIT_CYCLES - 1);
          end
        end
        TRAIN: begin
          if (!dfi.dfi_init_start) begin
            state    <= IDLE;
            init_cnt <= '0;
          end else if (init_cnt == '0) begin
            state <= DONE;
          end else begin
            init_cnt <= init_cnt - INIT_CNT_W'(1);
          end
        end
        DONE:    state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p0: qualify enables; nothing enters the data path before init completes
  logic         wr_p0;
  logic [E-1:0] rd_mask_p0;
  logic         push;
  logic [E-1:0] rd_mask_out;

  assign wr_p0      = active & (|dfi.dfi_wrdata_en);
  assign rd_mask_p0 = active ? dfi.dfi_rddata_en : '0;

  // Stage p1..: write flag delayed to line up with the write data
  generate
    if (C_TPHY_WRDATA == 0) begin : g_wr_nodly
      assign push = wr_p0;
    end else begin : g_wr_dly
      logic [C_TPHY_WRDATA-1:0] wr_dly_p1;
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          wr_dly_p1 <= '0;
        end else begin
          wr_dly_p1[0] <= wr_p0;
          for (int i = 1; i < C_TPHY_WRDATA; i++) wr_dly_p1[i] <= wr_dly_p1[i-1];
        end
      end
      assign push = wr_dly_p1[C_TPHY_WRDATA-1];
    end
  endgenerate

  // Read mask runs RDLAT-1 stages; the output register supplies the last cycle
  generate
    if (C_TPHY_RDLAT == 1) begin : g_rd_nodly
      assign rd_mask_out = rd_mask_p0;
    end else begin : g_rd_dly
      logic [E-1:0] rd_mask_p1 [C_TPHY_RDLAT-1];
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          for (int i = 0; i < C_TPHY_RDLAT - 1; i++) rd_mask_p1[i] <= '0;
        end else begin
          rd_mask_p1[0] <= rd_mask_p0;
          for (int i = 1; i < C_TPHY_RDLAT - 1; i++) rd_mask_p1[i] <= rd_mask_p1[i-1];
        end
      end
      assign rd_mask_out = rd_mask_p1[C_TPHY_RDLAT-2];
    end
  endgenerate

  logic         pop;
  logic [W-1:0] fifo_rdata;
  logic         fifo_full;
  logic         fifo_empty;
  logic         underflow;
  logic         overflow;

  assign pop       = |rd_mask_out;
  assign underflow = pop & fifo_empty;
  assign overflow  = push & fifo_full & ~(pop & ~fifo_empty);

  dfi_phy_fifo #(
    .DATA_W (W),
    .DEPTH  (C_FIFO_DEPTH)
  ) u_fifo (
    .clk   (aclk),
    .rst_n (aresetn),
    .push  (push),
    .wdata (dfi.dfi_wrdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Output stage: registered read return, sticky errors, handshake acks
  logic [W-1:0] rddata_out;
  logic [E-1:0] vld_out;
  logic [1:0]   error_q;
  logic         ctrlupd_ack_q;
  logic         lp_ack_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rddata_out    <= '0;
      vld_out       <= '0;
      error_q       <= '0;
      ctrlupd_ack_q <= 1'b0;
      lp_ack_q      <= 1'b0;
    end else begin
      vld_out       <= rd_mask_out;
      rddata_out    <= (pop && !fifo_empty) ? fifo_rdata : '0;
      if (underflow) error_q[ERR_UNDERFLOW] <= 1'b1;
      if (overflow)  error_q[ERR_OVERFLOW]  <= 1'b1;
      ctrlupd_ack_q <= dfi.dfi_ctrlupd_req;
      lp_ack_q      <= dfi.dfi_lp_ctrl_req | dfi.dfi_lp_data_req;
    end
  end

  assign dfi.dfi_rddata        = rddata_out;
  assign dfi.dfi_rddata_valid  = vld_out;
  assign dfi.dfi_init_complete = active;
  assign dfi.dfi_ctrlupd_ack   = ctrlupd_ack_q;
  assign dfi.dfi_lp_ack        = lp_ack_q;
  assign dfi.dfi_error         = error_q;
  assign dfi.dfi_phyupd_req    = 1'b0;
  assign dfi.dfi_phyupd_type   = 2'b00;
  assign dfi.dfi_alert_n       = 1'b1;

endmodule

// File: tb/tb_dfi_loopback_phy.sv
// Directed bench for dfi_loopback_phy: init handshake, loopback table, and
// hand-written overflow and reset-mid-read sequences.
module tb_dfi_loopback_phy;

  localparam int W = 64;
  localparam int E = 4;

  logic aclk;
  logic aresetn;

  dfi_loopback_phy_if #(.W(W), .E(E)) dfi ();

  dfi_loopback_phy #(
    .C_DFI_FREQ_RATIO   (4),
    .C_DFI_DATA_WIDTH   (16),
    .C_DFI_DATAEN_WIDTH (1),
    .C_TPHY_WRDATA      (1),
    .C_TPHY_RDLAT       (4),
    .C_INIT_CYCLES      (16),
    .C_FIFO_DEPTH       (16)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .dfi     (dfi)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic [3:0]  wr_en;
    logic [63:0] wrdata;
    logic [3:0]  rd_en;
    logic        ctrlupd;
    logic        lp_ctrl;
    logic        lp_data;
    logic [3:0]  exp_vld;
    logic [63:0] exp_data;
    logic [1:0]  exp_err;
    logic        exp_ack;
    logic        exp_lp;
  } vec_t;

  vec_t tbl [12];
  int   n_vec;
  int   n_err;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(string name, logic [79:0] act, logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [79:0] obs();
    return {8'h0, dfi.dfi_rddata_valid, dfi.dfi_rddata, dfi.dfi_error,
            dfi.dfi_ctrlupd_ack, dfi.dfi_lp_ack};
  endfunction

  function automatic logic [79:0] expv(logic [3:0] v, logic [63:0] d,
                                       logic [1:0] e, logic a, logic l);
    return {8'h0, v, d, e, a, l};
  endfunction

  function automatic logic [63:0] pat(int i);
    logic [15:0] k;
    k = 16'(i);
    return {16'hC0DE, k, 16'hBEEF, ~k};
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    aresetn = 1'b0;
    dfi.dfi_wrdata_en   = '0;
    dfi.dfi_wrdata      = '0;
    dfi.dfi_rddata_en   = '0;
    dfi.dfi_init_start  = 1'b0;
    dfi.dfi_ctrlupd_req = 1'b0;
    dfi.dfi_lp_ctrl_req = 1'b0;
    dfi.dfi_lp_data_req = 1'b0;

    //          wr    wrdata                  rd    cu  lc  ld   vld   data                    err    ack lp
    tbl[0]  = '{4'hF, 64'h0,                  4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 64'h0,                  2'b00, 1'b0, 1'b0};
    tbl[1]  = '{4'hF, 64'hA5A5_A5A5_A5A5_A5A5, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 64'h0,                  2'b00, 1'b1, 1'b0};
    tbl[2]  = '{4'hF, 64'h1234_5678_9ABC_DEF0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 64'h0,                  2'b00, 1'b1, 1'b0};
    tbl[3]  = '{4'h0, 64'hDEAD_BEEF_CAFE_F00D, 4'hF, 1'b1, 1'b0, 1'b0, 4'h0, 64'h0,                  2'b00, 1'b1, 1'b0};
    tbl[4]  = '{4'h0, 64'h0,                  4'hF, 1'b1, 1'b0, 1'b0, 4'h0, 64'h0,                  2'b00, 1'b1, 1'b0};
    tbl[5]  = '{4'h0, 64'h0,                  4'h3, 1'b0, 1'b0, 1'b0, 4'h0, 64'h0,                  2'b00, 1'b1, 1'b0};
    tbl[6]  = '{4'h0, 64'h0,                  4'hF, 1'b0, 1'b0, 1'b0, 4'h0, 64'h0,                  2'b00, 1'b0, 1'b0};
    tbl[7]  = '{4'h0, 64'h0,                  4'h0, 1'b0, 1'b0, 1'b1, 4'hF, 64'hA5A5_A5A5_A5A5_A5A5, 2'b00, 1'b0, 1'b0};
    tbl[8]  = '{4'h0, 64'h0,                  4'h0, 1'b0, 1'b0, 1'b0, 4'hF, 64'h1234_5678_9ABC_DEF0, 2'b00, 1'b0, 1'b1};
    tbl[9]  = '{4'h0, 64'h0,                  4'h0, 1'b0, 1'b1, 1'b0, 4'h3, 64'hDEAD_BEEF_CAFE_F00D, 2'b00, 1'b0, 1'b0};
    tbl[10] = '{4'h0, 64'h0,                  4'h0, 1'b0, 1'b0, 1'b0, 4'hF, 64'h0,                  2'b01, 1'b0, 1'b1};
    tbl[11] = '{4'h0, 64'h0,                  4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 64'h0,                  2'b01, 1'b0, 1'b0};

    // Reset state
    tick();
    tick();
    check("reset_outputs", obs(), 80'h0);
    check("reset_init_complete", {79'b0, dfi.dfi_init_complete}, 80'h0);
    check("tieoffs", {76'b0, dfi.dfi_phyupd_req, dfi.dfi_phyupd_type, dfi.dfi_alert_n}, 80'h1);
    aresetn = 1'b1;
    for (int i = 0; i < 10; i++) tick();

    // Init aborted after 5 cycles; enables during IDLE/TRAIN must be ignored
    dfi.dfi_init_start = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    dfi.dfi_init_start = 1'b0;
    dfi.dfi_wrdata_en  = 4'hF;
    dfi.dfi_wrdata     = 64'hFFFF_0000_FFFF_0000;
    dfi.dfi_rddata_en  = 4'hF;
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("abort_idle%0d", i),
            {dfi.dfi_init_complete, 3'b0, dfi.dfi_rddata_valid, 72'h0}, 80'h0);
    end
    dfi.dfi_wrdata_en = '0;
    dfi.dfi_wrdata    = '0;
    dfi.dfi_rddata_en = '0;
    tick();
    tick();
    check("no_error_before_init", obs(), 80'h0);

    // Re-assert: complete exactly 1+16 cycles after first high
    dfi.dfi_init_start = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    check("init_not_yet", {79'b0, dfi.dfi_init_complete}, 80'h0);
    tick();
    check("init_complete", {79'b0, dfi.dfi_init_complete}, 80'h1);

    // Loopback, partial enable, underflow, ctrlupd and lp handshakes
    for (int i = 0; i < 12; i++) begin
      dfi.dfi_wrdata_en   = tbl[i].wr_en;
      dfi.dfi_wrdata      = tbl[i].wrdata;
      dfi.dfi_rddata_en   = tbl[i].rd_en;
      dfi.dfi_ctrlupd_req = tbl[i].ctrlupd;
      dfi.dfi_lp_ctrl_req = tbl[i].lp_ctrl;
      dfi.dfi_lp_data_req = tbl[i].lp_data;
      check($sformatf("vec%0d", i), obs(),
            expv(tbl[i].exp_vld, tbl[i].exp_data, tbl[i].exp_err, tbl[i].exp_ack, tbl[i].exp_lp));
      tick();
    end

    // 17 writes into depth 16: last beat dropped, overflow sticky
    for (int c = 0; c < 18; c++) begin
      dfi.dfi_wrdata_en = (c < 17) ? 4'hF : 4'h0;
      dfi.dfi_wrdata    = (c >= 1) ? pat(c - 1) : 64'h0;
      tick();
    end
    dfi.dfi_wrdata_en = '0;
    dfi.dfi_wrdata    = '0;
    tick();
    check("overflow_err", {78'b0, dfi.dfi_error}, 80'h3);

    // Drain 16 beats back-to-back; beat 15 is the last one returned
    for (int c = 0; c < 20; c++) begin
      dfi.dfi_rddata_en = (c < 16) ? 4'hF : 4'h0;
      if (c >= 4)
        check($sformatf("readback%0d", c - 4), obs(), expv(4'hF, pat(c - 4), 2'b11, 1'b0, 1'b0));
      tick();
    end
    dfi.dfi_rddata_en = '0;
    check("readback_idle", obs(), expv(4'h0, 64'h0, 2'b11, 1'b0, 1'b0));

    // Reset between rddata_en and rddata_valid
    dfi.dfi_wrdata_en = 4'hF;
    tick();
    dfi.dfi_wrdata_en = '0;
    dfi.dfi_wrdata    = pat(99);
    tick();
    dfi.dfi_wrdata    = '0;
    dfi.dfi_rddata_en = 4'hF;
    tick();
    dfi.dfi_rddata_en = '0;
    tick();
    aresetn = 1'b0;
    dfi.dfi_init_start = 1'b0;
    #1;
    check("reset_async", {dfi.dfi_init_complete, 79'b0} | obs(), 80'h0);
    tick();
    aresetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("post_reset%0d", i), {dfi.dfi_init_complete, 79'b0} | obs(), 80'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
